// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// geometry constants, address field layout, FSM state encoding and
// word-select helpers used by the controller and its line array.
package dcache_pkg;

    localparam int unsigned LINE_IDX_W = 3;
    localparam int unsigned WORD_OFF_W = 2;
    localparam int unsigned ADDR_W     = 30;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TAG_W      = ADDR_W - LINE_IDX_W - WORD_OFF_W;
    localparam int unsigned LINE_W     = WORD_W << WORD_OFF_W;
    localparam int unsigned NUM_LINES  = 1 << LINE_IDX_W;
    localparam int unsigned BLK_ADDR_W = ADDR_W - WORD_OFF_W;

    // Field positions inside a processor word address.
    localparam int unsigned OFF_LSB = 0;
    localparam int unsigned IDX_LSB = OFF_LSB + WORD_OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + LINE_IDX_W;

    // Bit-position widths used when selecting a word inside a line.
    localparam int unsigned LINE_BIT_W = $clog2(LINE_W);
    localparam int unsigned WORD_BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Processor word address split into cache fields.
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [LINE_IDX_W-1:0] idx;
        logic [WORD_OFF_W-1:0] off;
    } proc_addr_t;

    // Lowest bit of word 'off' inside a line.
    function automatic logic [LINE_BIT_W-1:0] word_lsb(input logic [WORD_OFF_W-1:0] off);
        return {off, WORD_BIT_W'(0)};
    endfunction

    // Extract word 'off' from a line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                    input logic [WORD_OFF_W-1:0] off);
        return line[word_lsb(off) +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Bundle of the cache's processor-side and memory-side signals.
//   slave  : view taken by the cache (serves the core, initiates to memory)
//   master : view taken by the environment (core + block memory)
interface dcache_if;
    import dcache_pkg::*;

    // Processor side
    logic                  proc_read;
    logic                  proc_write;
    logic [ADDR_W-1:0]     proc_addr;
    logic [WORD_W-1:0]     proc_wdata;
    logic                  proc_stall;
    logic [WORD_W-1:0]     proc_rdata;

    // Block memory side
    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_stall, proc_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_stall, proc_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/dcache_line_array.sv
// Storage for the cache lines: valid/dirty bits (asynchronously cleared),
// tags and data (never cleared). One combinational read port, one
// synchronous word-write port (marks the line dirty) and one synchronous
// line-fill port (marks the line valid and clean).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   rd_idx -> rd_valid/dirty/tag/data combinational line read
//   wr_en, wr_idx, wr_off, wr_word    store-hit word write
//   fill_en, fill_idx, fill_tag/data  refill from memory
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [LINE_IDX_W-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_data,

    input  logic                  wr_en,
    input  logic [LINE_IDX_W-1:0] wr_idx,
    input  logic [WORD_OFF_W-1:0] wr_off,
    input  logic [WORD_W-1:0]     wr_word,

    input  logic                  fill_en,
    input  logic [LINE_IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [LINE_W-1:0]     fill_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Line state bits; a fill takes priority over a word write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset: contents are meaningless until valid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_q[wr_idx][word_lsb(wr_off) +: WORD_W] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Serves load/store requests from the MEM stage and fetches / writes back
// 128-bit blocks from / to the block memory with a mem_ready handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  proc_read/write/addr/wdata in, proc_stall/rdata out;
//                mem_read/write/addr/wdata out, mem_rdata/ready in
// proc_stall and proc_rdata are combinational so a hit completes in the
// cycle it is presented. Memory-side outputs decode the state register
// only, so an asynchronous reset drops them immediately.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    dcache_if.slave  bus
);

    proc_addr_t             pa;
    state_t                 state_q;
    state_t                 state_d;

    logic                   rd_valid;
    logic                   rd_dirty;
    logic [TAG_W-1:0]       rd_tag;
    logic [LINE_W-1:0]      rd_data;

    logic                   req;
    logic                   hit;
    logic                   wr_hit;
    logic                   fill_en;

    logic                   stall_c;
    logic                   mem_read_c;
    logic                   mem_write_c;
    logic [BLK_ADDR_W-1:0]  mem_addr_c;
    logic [LINE_W-1:0]      mem_wdata_c;

    // Address and store data are held stable by the core while stalled,
    // so they are used directly rather than captured.
    assign pa = bus.proc_addr;

    assign req     = bus.proc_read | bus.proc_write;
    assign hit     = rd_valid && (rd_tag == pa.tag);
    // A combined read+write is a write; the store lands on the hit cycle.
    assign wr_hit  = (state_q == COMPARE) && bus.proc_write && hit;
    assign fill_en = (state_q == ALLOCATE) && bus.mem_ready;

    dcache_line_array u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pa.idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_hit),
        .wr_idx    (pa.idx),
        .wr_off    (pa.off),
        .wr_word   (bus.proc_wdata),
        .fill_en   (fill_en),
        .fill_idx  (pa.idx),
        .fill_tag  (pa.tag),
        .fill_data (bus.mem_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-side request decode.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;

        unique case (state_q)
            COMPARE: begin
                if (req && !hit) begin
                    stall_c = 1'b1;
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                // Victim still resident at this index until the refill lands.
                stall_c     = 1'b1;
                mem_write_c = 1'b1;
                mem_addr_c  = {rd_tag, pa.idx};
                mem_wdata_c = rd_data;
                if (bus.mem_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_c    = 1'b1;
                mem_read_c = 1'b1;
                mem_addr_c = {pa.tag, pa.idx};
                if (bus.mem_ready) begin
                    state_d = COMPARE;
                end
            end
            default: begin
                state_d = COMPARE;
            end
        endcase
    end

    // Stall is forced low while reset is asserted so a held request does not
    // show as a miss against the freshly cleared valid bits.
    assign bus.proc_stall = rst_n & stall_c;
    assign bus.proc_rdata = (bus.proc_read && hit) ? line_word(rd_data, pa.off) : '0;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, reset and ignored-ready
// sequences, then random traffic checked against a flat-memory reference
// (a load returns the last value stored to that word) plus a tag model
// predicting which memory phases each access needs.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_if bus ();

    dcache_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Block memory model state
    int          lat  = 2;
    int          mcnt = 0;
    logic [27:0] req_addr;
    logic [127:0] req_data;
    int          wb_cnt = 0;
    int          rd_cnt = 0;
    logic [27:0] last_wb_addr;
    logic [27:0] last_rd_addr;
    logic [127:0] last_wb_data;
    logic [127:0] mem_store [bit [27:0]];

    // Reference: flat word memory + tag model
    logic [31:0] ref_mem [bit [29:0]];
    bit          m_valid [8];
    bit          m_dirty [8];
    bit [24:0]   m_tag   [8];

    typedef struct {
        bit          rd;
        bit          wr;
        bit [29:0]   addr;
        bit [31:0]   wd;
        int          lt;
        bit [31:0]   exp_rdata;
        int          exp_cyc;
        int          exp_wb;
        int          exp_rd;
        bit [27:0]   exp_wb_addr;
        bit [27:0]   exp_rd_addr;
        bit [127:0]  exp_wb_data;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] blk(input bit [27:0] a);
        logic [127:0] b;
        if (mem_store.exists(a)) return mem_store[a];
        for (int w = 0; w < 4; w++) b[32*w +: 32] = {a, 2'(w), 2'b01};
        return b;
    endfunction

    function automatic logic [31:0] ref_rd(input bit [29:0] a);
        logic [127:0] b;
        if (ref_mem.exists(a)) return ref_mem[a];
        b = blk(a[29:2]);
        return b[32*int'(a[1:0]) +: 32];
    endfunction

    // One memory-model step, at the negative edge.
    task automatic mem_step();
        bus.mem_ready = 1'b0;
        if (bus.mem_read || bus.mem_write) begin
            chk("mem_excl", 128'(bus.mem_read & bus.mem_write), 128'(0));
            if (mcnt == 0) begin
                req_addr = bus.mem_addr;
                req_data = bus.mem_wdata;
            end else begin
                chk("mem_addr_hold", 128'(bus.mem_addr), 128'(req_addr));
                if (bus.mem_write) chk("mem_wdata_hold", bus.mem_wdata, req_data);
            end
            mcnt++;
            if (mcnt >= lat) begin
                if (bus.mem_write) begin
                    mem_store[req_addr] = req_data;
                    wb_cnt++;
                    last_wb_addr = req_addr;
                    last_wb_data = req_data;
                end else begin
                    bus.mem_rdata = blk(req_addr);
                    rd_cnt++;
                    last_rd_addr = req_addr;
                end
                bus.mem_ready = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
    endtask

    // Present one request (starting just after a posedge) until it completes.
    task automatic access(input bit rd, input bit wr, input bit [29:0] a, input bit [31:0] wd,
                          output logic [31:0] rdata, output int cyc);
        bit done;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        cyc   = 0;
        rdata = '0;
        done  = 1'b0;
        while (!done) begin
            tick();
            if (!bus.proc_stall) begin
                rdata = bus.proc_rdata;
                done  = 1'b1;
            end else begin
                cyc++;
                if (cyc > 300) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stall_timeout: still stalled after %0d cycles, addr=%h", cyc, a);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    // Predict memory phases and victim contents, then apply the access to the reference.
    task automatic model_access(input bit wr, input bit [29:0] a, input bit [31:0] wd,
                                output int e_wb, output int e_rd,
                                output bit [27:0] e_wb_addr, output bit [127:0] e_wb_data);
        bit [2:0]  idx = a[4:2];
        bit [24:0] tag = a[29:5];
        e_wb = 0;
        e_rd = 0;
        e_wb_addr = '0;
        e_wb_data = '0;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                e_wb = 1;
                e_wb_addr = {m_tag[idx], idx};
                for (int w = 0; w < 4; w++)
                    e_wb_data[32*w +: 32] = ref_rd({m_tag[idx], idx, 2'(w)});
            end
            e_rd = 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_dirty[idx] = 1'b1;
            ref_mem[a]   = wd;
        end
    endtask

    // Full model-checked access used by random traffic and post-reset checks.
    task automatic checked_access(input string tag_s, input bit rd, input bit wr,
                                  input bit [29:0] a, input bit [31:0] wd);
        int e_wb, e_rd, wb0, rd0, cyc, ph;
        bit [27:0] e_wb_addr;
        bit [127:0] e_wb_data;
        logic [31:0] got, exp_val;
        exp_val = ref_rd(a);
        wb0 = wb_cnt;
        rd0 = rd_cnt;
        model_access(wr, a, wd, e_wb, e_rd, e_wb_addr, e_wb_data);
        access(rd, wr, a, wd, got, cyc);
        ph = e_wb + e_rd;
        if (rd && !wr) chk({tag_s, "_rdata"}, 128'(got), 128'(exp_val));
        chk({tag_s, "_cycles"}, 128'(cyc), 128'((ph == 0) ? 0 : 1 + ph * lat));
        chk({tag_s, "_wb"}, 128'(wb_cnt - wb0), 128'(e_wb));
        chk({tag_s, "_rd"}, 128'(rd_cnt - rd0), 128'(e_rd));
        if (e_wb != 0) begin
            chk({tag_s, "_wb_addr"}, 128'(last_wb_addr), 128'(e_wb_addr));
            chk({tag_s, "_wb_data"}, last_wb_data, e_wb_data);
        end
        if (e_rd != 0) chk({tag_s, "_rd_addr"}, 128'(last_rd_addr), 128'(a[29:2]));
    endtask

    initial begin
        int          wb0, rd0, cyc, e_wb, e_rd;
        bit [27:0]   ea;
        bit [127:0]  ed;
        logic [31:0] got;
        bit          saw;
        bit [29:0]   ra;
        int          op;

        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        rst_n = 1'b0;
        mem_store[28'h1] = {32'hD, 32'hC, 32'hB, 32'hA};

        //               rd wr addr    wdata         lat rdata         cyc wb rd wb_addr rd_addr wb_data
        tbl[0] = '{1, 0, 30'h05, 32'h0,         2, 32'hB,         3,  0, 1, 28'h0,  28'h1,  128'h0};
        tbl[1] = '{0, 1, 30'h05, 32'hDEAD_BEEF, 2, 32'h0,         0,  0, 0, 28'h0,  28'h0,  128'h0};
        tbl[2] = '{1, 0, 30'h05, 32'h0,         2, 32'hDEAD_BEEF, 0,  0, 0, 28'h0,  28'h0,  128'h0};
        tbl[3] = '{1, 0, 30'h04, 32'h0,         2, 32'hA,         0,  0, 0, 28'h0,  28'h0,  128'h0};
        tbl[4] = '{1, 0, 30'h25, 32'h0,         2, 32'h95,        5,  1, 1, 28'h1,  28'h9,
                   {32'hD, 32'hC, 32'hDEAD_BEEF, 32'hA}};
        tbl[5] = '{1, 0, 30'h05, 32'h0,         2, 32'hDEAD_BEEF, 3,  0, 1, 28'h0,  28'h1,  128'h0};
        tbl[6] = '{1, 0, 30'h25, 32'h0,         2, 32'h95,        3,  0, 1, 28'h0,  28'h9,  128'h0};
        tbl[7] = '{0, 1, 30'h45, 32'hCAFE_F00D, 7, 32'h0,         8,  0, 1, 28'h0,  28'h11, 128'h0};
        tbl[8] = '{1, 0, 30'h05, 32'h0,         7, 32'hDEAD_BEEF, 15, 1, 1, 28'h11, 28'h1,
                   {32'h11D, 32'h119, 32'hCAFE_F00D, 32'h111}};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_stall", 128'(bus.proc_stall), 128'(0));
        chk("rst_rdata", 128'(bus.proc_rdata), 128'(0));
        chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
        chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            lat = tbl[i].lt;
            wb0 = wb_cnt;
            rd0 = rd_cnt;
            model_access(tbl[i].wr, tbl[i].addr, tbl[i].wd, e_wb, e_rd, ea, ed);
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, got, cyc);
            if (tbl[i].rd && !tbl[i].wr)
                chk($sformatf("v%0d_rdata", i), 128'(got), 128'(tbl[i].exp_rdata));
            chk($sformatf("v%0d_cycles", i), 128'(cyc), 128'(tbl[i].exp_cyc));
            chk($sformatf("v%0d_wb", i), 128'(wb_cnt - wb0), 128'(tbl[i].exp_wb));
            chk($sformatf("v%0d_rd", i), 128'(rd_cnt - rd0), 128'(tbl[i].exp_rd));
            if (tbl[i].exp_wb != 0) begin
                chk($sformatf("v%0d_wb_addr", i), 128'(last_wb_addr), 128'(tbl[i].exp_wb_addr));
                chk($sformatf("v%0d_wb_data", i), last_wb_data, tbl[i].exp_wb_data);
            end
            if (tbl[i].exp_rd != 0)
                chk($sformatf("v%0d_rd_addr", i), 128'(last_rd_addr), 128'(tbl[i].exp_rd_addr));
        end

        // Stray mem_ready while idle must not disturb the resident line
        lat = 2;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{32'hBAD0_BAD0}};
        tick();
        @(posedge clk);
        #1;
        checked_access("stray_ready", 1'b1, 1'b0, 30'h05, 32'h0);

        // Reset while ALLOCATE is waiting on memory
        lat = 50;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h25;
        saw = 1'b0;
        for (int k = 0; k < 20 && !saw; k++) begin
            tick();
            saw = bus.mem_read;
        end
        chk("mid_alloc_seen", 128'(saw), 128'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_read", 128'(bus.mem_read), 128'(0));
        chk("mid_rst_mem_write", 128'(bus.mem_write), 128'(0));
        chk("mid_rst_stall", 128'(bus.proc_stall), 128'(0));
        tick();
        tick();
        #1;
        rst_n = 1'b1;
        bus.proc_read = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_dirty[k] = 1'b0;
        end
        ref_mem.delete();
        @(posedge clk);
        #1;
        lat = 2;
        checked_access("post_rst_a", 1'b1, 1'b0, 30'h25, 32'h0);
        checked_access("post_rst_b", 1'b1, 1'b0, 30'h05, 32'h0);

        // Random traffic over a few tags so index conflicts are frequent
        for (int k = 0; k < 400; k++) begin
            ra  = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op  = int'($urandom_range(0, 3));
            lat = int'($urandom_range(1, 4));
            checked_access("rnd", (op == 0 || op == 2 || op == 3), (op == 1 || op == 3), ra, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
